// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Four-way intersection phase scheduler. One approach at a time gets green.
// The next approach is chosen by round-robin over the vehicle-presence
// requests, or by emergency preemption. Every handover goes green -> yellow
// -> all-red. All interval timing counts 'tick' strobes, not clk cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active-high (historic name kept)
//   tick         one-cycle timebase strobe; timers move only when tick=1
//   req[3:0]     level presence requests, bit0=N bit1=E bit2=S bit3=W
//   emerg_valid  emergency preemption request (level)
//   emerg_dir    emergency approach, 0=N 1=E 2=S 3=W
//   north/east/south/west  lights, 001=red 010=yellow 100=green
//   active_dir   approach owning the phase (green or yellow)
//   phase        FSM state, 0=ALLRED 1=GREEN 2=YELLOW (also the debug view)
//   emerg_ack    emergency approach holds green while emerg_valid is high
//
// There are no valid/ready handshakes in this block. req and emerg_valid are
// levels and are sampled on every clk edge.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CW        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emerg_valid,
    input  logic [1:0] emerg_dir,
    output logic [2:0] north,
    output logic [2:0] east,
    output logic [2:0] south,
    output logic [2:0] west,
    output logic [1:0] active_dir,
    output logic [1:0] phase,
    output logic       emerg_ack
);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    localparam logic [CW-1:0] T_GMIN   = CW'(GREEN_MIN);
    localparam logic [CW-1:0] T_GMAX   = CW'(GREEN_MAX);
    localparam logic [CW-1:0] T_YELLOW = CW'(YELLOW_T);
    localparam logic [CW-1:0] T_ALLRED = CW'(ALLRED_T);
    localparam logic [CW-1:0] T_ONE    = CW'(1);

    phase_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [CW-1:0] elapsed_q, elapsed_d;
    logic [1:0]    active_q, active_d;
    logic [1:0]    last_q, last_d;
    logic          ack_q, ack_d;

    logic [1:0]    cand;
    logic          cand_valid;
    logic [1:0]    scan_idx;
    logic [CW-1:0] e_inc;
    logic          other_pending;
    logic [2:0]    lamp;

    // Candidate: an emergency overrides round-robin. Otherwise scan from the
    // approach after the last one served; k=4 wraps back to last_served so it
    // is considered last.
    always_comb begin
        cand       = 2'd0;
        cand_valid = 1'b0;
        scan_idx   = 2'd0;
        if (emerg_valid) begin
            cand       = emerg_dir;
            cand_valid = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                scan_idx = 2'(int'(last_q) + k);
                if (!cand_valid && req[scan_idx]) begin
                    cand       = scan_idx;
                    cand_valid = 1'b1;
                end
            end
        end
    end

    // Elapsed green after this tick, saturating so it never wraps.
    assign e_inc         = (elapsed_q >= T_GMAX) ? T_GMAX : elapsed_q + T_ONE;
    assign other_pending = |(req & ~(4'b0001 << active_q));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        elapsed_d = elapsed_q;
        active_d  = active_q;
        last_d    = last_q;
        case (state_q)
            PH_ALLRED: begin
                // Grant on the tick that completes the clearance, or at any
                // edge once clearance has fully expired.
                if (cand_valid && ((timer_q == '0) || (tick && timer_q == T_ONE))) begin
                    state_d   = PH_GREEN;
                    active_d  = cand;
                    last_d    = cand;
                    elapsed_d = '0;
                end else if (tick && timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end
            end
            PH_GREEN: begin
                if (emerg_valid && emerg_dir != active_q) begin
                    // Preemption for another approach ignores tick and GREEN_MIN.
                    state_d = PH_YELLOW;
                    timer_d = T_YELLOW;
                end else if (tick) begin
                    elapsed_d = e_inc;
                    // An emergency for the active approach holds green.
                    if (!emerg_valid && e_inc >= T_GMIN && other_pending &&
                        (e_inc >= T_GMAX || !req[active_q])) begin
                        state_d = PH_YELLOW;
                        timer_d = T_YELLOW;
                    end
                end
            end
            PH_YELLOW: begin
                if (tick) begin
                    if (timer_q <= T_ONE) begin
                        state_d = PH_ALLRED;
                        timer_d = T_ALLRED;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
            end
            default: begin
                state_d = PH_ALLRED;
                timer_d = T_ALLRED;
            end
        endcase
        // The ack is registered so that no output has a combinational path
        // from an input. It tracks the state being entered at this edge.
        ack_d = (state_d == PH_GREEN) && emerg_valid && (emerg_dir == active_d);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= PH_ALLRED;
            timer_q   <= T_ALLRED;
            elapsed_q <= '0;
            active_q  <= 2'd0;
            last_q    <= 2'd3;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            active_q  <= active_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
        end
    end

    // The lights are decoded from state only. Reset forces every light red
    // at once, because the reset clears state_q asynchronously.
    assign lamp = (state_q == PH_GREEN)  ? 3'b100 :
                  (state_q == PH_YELLOW) ? 3'b010 : 3'b001;

    assign north      = (active_q == 2'd0) ? lamp : 3'b001;
    assign east       = (active_q == 2'd1) ? lamp : 3'b001;
    assign south      = (active_q == 2'd2) ? lamp : 3'b001;
    assign west       = (active_q == 2'd3) ? lamp : 3'b001;
    assign active_dir = active_q;
    assign phase      = state_q;
    assign emerg_ack  = ack_q;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Adaptive phase scheduler for a four-way intersection (N, E, S, W). It grants green to one approach at a time, using round-robin arbitration over vehicle-presence requests. Every handover passes through a yellow interval and then an all-red clearance interval. The block supports minimum and maximum green times, gap-out, rest-in-green and emergency-vehicle preemption. All timing is counted in `tick` pulses from the system timebase, so `clk` can run fast.

Parameters:
GREEN_MIN, 4, minimum green length in ticks (GREEN_MIN >= 1)
GREEN_MAX, 8, maximum green length in ticks when another approach is waiting (GREEN_MIN <= GREEN_MAX < 2**CW)
YELLOW_T, 2, yellow length in ticks (>= 1)
ALLRED_T, 1, all-red clearance length in ticks (>= 1)
CW, 6, width of the internal timer counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle timebase strobe; all timers advance only on cycles where tick=1
req  in  4  level vehicle-presence requests; bit0=N, bit1=E, bit2=S, bit3=W
emerg_valid  in  1  emergency preemption request, level
emerg_dir  in  2  emergency approach; 0=N, 1=E, 2=S, 3=W
north  out  3  light; 001=red, 010=yellow, 100=green
east  out  3  light; same encoding as north
south  out  3  light; same encoding as north
west  out  3  light; same encoding as north
active_dir  out  2  approach currently owning the phase (green or yellow)
phase  out  2  state; 0=ALLRED, 1=GREEN, 2=YELLOW
emerg_ack  out  1  high while in GREEN with active_dir==emerg_dir and emerg_valid=1

Behaviour:
- Reset (asynchronous, any time, including mid-phase):
  - phase=ALLRED, timer=ALLRED_T, green elapsed=0.
  - active_dir=0; last_served=3, so N has first priority.
  - All lights 001; emerg_ack=0.
  - Lights go red immediately, without waiting for a clock edge.
- Outputs are decoded only from state registers, with no combinational path from inputs.
  - Only active_dir's light can be non-red, and only in GREEN (100) or YELLOW (010).
  - The light sequence per approach is strictly green -> yellow -> red.
- Candidate selection:
  - If emerg_valid=1, the candidate is emerg_dir.
  - Otherwise, scan req round-robin starting at last_served+1 mod 4 and take the first set bit.
  - If no bit is set, there is no candidate.
- ALLRED:
  - On each tick with timer > 0, timer decrements.
  - When timer is 1 on a tick, or timer is already 0 (tick not required), and a candidate exists: next edge goes to GREEN, active_dir=candidate, last_served=candidate, elapsed=0.
  - With no candidate, stay in ALLRED with timer at 0.
  - A req bit dropped before the grant edge is not granted.
- GREEN:
  - elapsed increments on tick, saturating at GREEN_MAX; let e' be the incremented value.
  - other_pending = any req bit set except active_dir's.
  - Normal end: go to YELLOW (timer=YELLOW_T) at a tick edge when e' >= GREEN_MIN and other_pending and (e' >= GREEN_MAX or req[active_dir]=0).
  - Rest-in-green: with no other_pending, green holds indefinitely, even if req[active_dir]=0.
  - Emergency for another approach (emerg_valid=1, emerg_dir != active_dir): go to YELLOW at the next clk edge regardless of tick or GREEN_MIN.
  - Emergency for the active approach: the normal end condition is suppressed while emerg_valid=1; emerg_ack=1.
- YELLOW:
  - Timer decrements on tick.
  - On a tick with timer==1, go to ALLRED with timer=ALLRED_T.
  - Yellow and all-red are never shortened by emergency. A pending emergency is served at the ALLRED grant.
- Simultaneous events:
  - Emergency overrides round-robin.
  - If emerg_dir changes during YELLOW or ALLRED, the value present at the grant edge wins.
  - emerg_valid dropping during GREEN re-enables the normal end rule on the next tick, using the current elapsed.
- Timing: each interval lasts exactly its parameter count of ticks, with no off-by-one. Counters never wrap; elapsed saturates.

Test Plan:
All scenarios use default parameters and tick=1 every cycle unless stated.
1. Idle then request:
   - Release reset with req=0000 -> all lights 001 and phase=0 for 20 cycles.
   - Set req=0001 -> north=100 at the next edge, with active_dir=0.
2. Full rotation under saturation:
   - Hold req=1111 -> greens in order N, E, S, W, N.
   - Each approach: 8 ticks green, 2 ticks yellow, 1 tick all-red.
   - Never more than one non-red light at any time.
3. Rest-in-green then max-out:
   - Hold req=0010 -> east=100 indefinitely (check 50 cycles).
   - Assert req bit2 -> east=010 on the first tick where elapsed reaches 8.
   - Then south=100 after 2 yellow ticks and 1 all-red tick.
4. Gap-out and reduced tick rate:
   - Set tick=1 every 3rd cycle, req=0101, N green.
   - Drop req bit0 at elapsed 2 -> north=010 exactly at the 4th tick.
5. Emergency preemption:
   - N green with elapsed 1; set emerg_valid=1, emerg_dir=3 -> north=010 next edge, ignoring GREEN_MIN.
   - After 2 yellow ticks and 1 all-red tick: west=100, emerg_ack=1.
   - West holds beyond 8 ticks with req=1111 while emerg_valid=1.
   - Drop emerg_valid -> west=010 on the next tick.
6. Asynchronous reset mid-green:
   - Assert rst_n between clk edges during S green -> all lights 001 immediately.
   - After release with req=1111 -> N is granted first.
